// File: rtl/color_step_ctrl_pkg.sv
// Shared definitions for the colour step controller: FSM encoding, RGB888 slicing,
// coefficient width and the step-to-coefficient mapping.
package color_step_ctrl_pkg;

    localparam int unsigned CoefW = 10;
    localparam int unsigned ChanW = 8;
    localparam int unsigned RLsb  = 16;
    localparam int unsigned GLsb  = 8;
    localparam int unsigned BLsb  = 0;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StArmed = 2'd1;
    localparam logic [1:0] StApply = 2'd2;

    typedef struct packed {
        logic [CoefW-1:0] kr;
        logic [CoefW-1:0] kg;
        logic [CoefW-1:0] kb;
    } coef_t;

    // Products wrap modulo 2^CoefW (e.g. step 31 gives kr = 1054 mod 1024 = 30).
    function automatic coef_t calc_coefs(logic [4:0] s);
        logic [CoefW-1:0] sw;
        coef_t            c;
        sw   = {{(CoefW-5){1'b0}}, s};
        c.kr = (sw + CoefW'(3)) * sw;
        c.kg = (sw + CoefW'(2)) * sw;
        c.kb = sw * sw;
        return c;
    endfunction

endpackage

// File: rtl/color_scale_ch.sv
// One colour channel scaler: 8-bit channel times 10-bit coefficient, truncated to
// 8 bits, or passed through unchanged when bypass is set.
module color_scale_ch
    import color_step_ctrl_pkg::*;
(
    input  logic [ChanW-1:0] ch_in,
    input  logic [CoefW-1:0] coef,
    input  logic             bypass,
    output logic [ChanW-1:0] ch_out
);

    logic [ChanW+CoefW-1:0] prod;
    logic                   unused_prod_hi;

    always_comb begin
        prod           = {{CoefW{1'b0}}, ch_in} * {{ChanW{1'b0}}, coef};
        unused_prod_hi = ^prod[ChanW+CoefW-1:ChanW];
        ch_out         = bypass ? ch_in : prod[ChanW-1:0];
    end

endmodule

// File: rtl/color_step_ctrl.sv
// Step controller: button/auto requests advance a step index at frame boundaries,
// and a two-stage pipeline scales RGB888 pixels by step-derived coefficients.
module color_step_ctrl
    import color_step_ctrl_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 30,
    parameter int unsigned MAX_STEP        = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_btn,
    input  logic        auto_en,
    input  logic        frame_start,
    input  logic [23:0] pixel_in,
    input  logic        pixel_valid_in,
    output logic [23:0] pixel_out,
    output logic        pixel_valid_out,
    output logic [4:0]  step,
    output logic        shft
);

    localparam logic [7:0] FrameLast = 8'(FRAMES_PER_STEP - 1);
    localparam logic [4:0] StepLast  = 5'(MAX_STEP);

    logic [1:0]  state_q, state_d;
    logic [4:0]  step_q, step_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    coef_t       coef_q, coef_d;
    logic        btn_q;
    logic        blind_q;
    logic        btn_req, auto_req, req;

    logic [23:0] s1_pix_q;
    logic        s1_valid_q;
    logic        s1_bypass_q;
    coef_t       s1_coef_q;
    logic [23:0] scaled;
    logic [23:0] pix_out_q;
    logic        valid_out_q;

    always_comb begin
        // blind_q masks a button already held high when reset is released
        btn_req     = step_btn & ~btn_q & ~blind_q;
        auto_req    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (!auto_en) begin
            frame_cnt_d = '0;
        end else if (frame_start) begin
            if (frame_cnt_q == FrameLast) begin
                auto_req    = 1'b1;
                frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
        req = btn_req | auto_req;

        state_d = state_q;
        step_d  = step_q;
        coef_d  = coef_q;
        case (state_q)
            StIdle:  if (req) state_d = StArmed;
            StArmed: if (frame_start) state_d = StApply;
            StApply: begin
                state_d = StIdle;
                step_d  = (step_q == StepLast) ? 5'd0 : step_q + 5'd1;
                coef_d  = calc_coefs(step_d);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            step_q      <= '0;
            frame_cnt_q <= '0;
            coef_q      <= '0;
            btn_q       <= 1'b0;
            blind_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            frame_cnt_q <= frame_cnt_d;
            coef_q      <= coef_d;
            btn_q       <= step_btn;
            blind_q     <= 1'b0;
        end
    end

    // Stage 1 captures the coefficients current at entry so a step change cannot
    // split a pixel across two settings.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_pix_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_bypass_q <= 1'b1;
            s1_coef_q   <= '0;
            pix_out_q   <= '0;
            valid_out_q <= 1'b0;
        end else begin
            s1_pix_q    <= pixel_in;
            s1_valid_q  <= pixel_valid_in;
            s1_bypass_q <= (step_q == 5'd0);
            s1_coef_q   <= coef_q;
            valid_out_q <= s1_valid_q;
            if (s1_valid_q) begin
                pix_out_q <= scaled;
            end
        end
    end

    color_scale_ch u_scale_r (
        .ch_in  (s1_pix_q[RLsb +: ChanW]),
        .coef   (s1_coef_q.kr),
        .bypass (s1_bypass_q),
        .ch_out (scaled[RLsb +: ChanW])
    );

    color_scale_ch u_scale_g (
        .ch_in  (s1_pix_q[GLsb +: ChanW]),
        .coef   (s1_coef_q.kg),
        .bypass (s1_bypass_q),
        .ch_out (scaled[GLsb +: ChanW])
    );

    color_scale_ch u_scale_b (
        .ch_in  (s1_pix_q[BLsb +: ChanW]),
        .coef   (s1_coef_q.kb),
        .bypass (s1_bypass_q),
        .ch_out (scaled[BLsb +: ChanW])
    );

    assign pixel_out       = pix_out_q;
    assign pixel_valid_out = valid_out_q;
    assign step            = step_q;
    assign shft            = (state_q == StApply);

endmodule
